if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_if.sv | 48 ++++
 rtl/if_id_buffer.sv | 96 +++++++++
 2 files changed

// File: rtl/if_id_buffer_if.sv
// rtl/if_id_buffer_if.sv - fetch/decode handshake and field bundle for the IF/ID skid buffer (flush under IF_ID_FLUSH_EN)
interface if_id_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
`ifdef IF_ID_FLUSH_EN
    logic        flush;

    // Environment side: offers instructions, consumes the head, may flush
    modport master (
        output in_valid, in_instr, in_pc, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_pc4,
        input  opcode, rs, rt, rd, funct, imm16
    );

    // Buffer side
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, flush,
        output in_ready, out_valid, out_pc, out_pc4,
        output opcode, rs, rt, rd, funct, imm16
    );
`else
    // Environment side: offers instructions, consumes the head
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_pc4,
        input  opcode, rs, rt, rd, funct, imm16
    );

    // Buffer side
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_pc4,
        output opcode, rs, rt, rd, funct, imm16
    );
`endif
endinterface

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - two-entry IF/ID skid buffer with field decode; optional flush under IF_ID_FLUSH_EN
module if_id_buffer (
    input  logic           clk,
    input  logic           reset_n,
    if_id_buffer_if.slave  bus
);
    // head_* is the entry presented to decode, tail_* the one behind it
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic [31:0] tail_instr;
    logic [31:0] tail_pc;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic        head_valid;
    logic        flush_now;

    // Handshake flags come only from registered count, so no combinational
    // path runs from in_valid/out_ready back to the ready/valid outputs
    assign head_valid   = (count != 2'd0);
    assign bus.in_ready = (count != 2'd2);
    assign bus.out_valid = head_valid;

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_ready & head_valid;

`ifdef IF_ID_FLUSH_EN
    assign flush_now = bus.flush;
`else
    assign flush_now = 1'b0;
`endif

    // Entry storage and occupancy; reset beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count      <= 2'd0;
            head_instr <= 32'd0;
            head_pc    <= 32'd0;
            tail_instr <= 32'd0;
            tail_pc    <= 32'd0;
        end else if (flush_now) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // Fill the first free slot
                    if (count == 2'd0) begin
                        head_instr <= bus.in_instr;
                        head_pc    <= bus.in_pc;
                    end else begin
                        tail_instr <= bus.in_instr;
                        tail_pc    <= bus.in_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Second entry (if any) moves up to the head
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count 1: the new entry replaces the head
                    head_instr <= bus.in_instr;
                    head_pc    <= bus.in_pc;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    // Field decode of the head entry, forced to zero while nothing is presented
    always_comb begin
        bus.out_pc  = 32'd0;
        bus.out_pc4 = 32'd0;
        bus.opcode  = 6'd0;
        bus.rs      = 5'd0;
        bus.rt      = 5'd0;
        bus.rd      = 5'd0;
        bus.funct   = 6'd0;
        bus.imm16   = 16'd0;
        if (head_valid) begin
            bus.out_pc  = head_pc;
            bus.out_pc4 = head_pc + 32'd4;
            bus.opcode  = head_instr[31:26];
            bus.rs      = head_instr[25:21];
            bus.rt      = head_instr[20:16];
            bus.rd      = head_instr[15:11];
            bus.funct   = head_instr[5:0];
            bus.imm16   = head_instr[15:0];
        end
    end
endmodule
